// File: rtl/wide_and_stim_check.sv
// -----------------------------------------------------------------------------
// wide_and_stim_check
//
// At-speed stimulus generator and result monitor for a registered wide-AND
// stage. Each accepted start runs one burst of patterns and the block compares
// the stage's 1-bit result against an internally computed expected value.
//
// Burst sequence: all ones, all zeros, walking zero (WIDTH patterns), then an
// optional LFSR section, then LATENCY drain cycles and a one-cycle FIN.
//
// Optional feature macro: WIDE_AND_STIM_LFSR_EN
//   defined   : 32-bit Galois LFSR section of LFSR_COUNT patterns after WALK
//   undefined : LFSR state/logic removed, LFSR_COUNT ignored
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   burst request, only sampled in IDLE
//   dat_o      out  [WIDTH-1:0] registered pattern to the DUT data input
//   dut_out    in   DUT result, LATENCY cycles behind dat_o
//   busy       out  high while a burst is in progress
//   done       out  one-cycle pulse at the end of a burst
//   pass       out  last burst finished with err_count == 0
//   err_count  out  [15:0] saturating mismatch count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module wide_and_stim_check #(
   parameter int WIDTH      = 16,
   parameter int LATENCY    = 2,
   parameter int LFSR_COUNT = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] dat_o,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count
);

   // Elaboration-time parameter legality.
   generate
      if (WIDTH < 2 || WIDTH > 128 || LATENCY < 1 || LATENCY > 8 ||
          LFSR_COUNT < 1 || LFSR_COUNT > 65535) begin : g_bad_param
         $error("wide_and_stim_check: parameter out of legal range");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE, ONES, ZEROS, WALK, LFSR, DRAIN, FIN
   } state_t;

   state_t               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]     dat_o_q, dat_o_d;
   logic                 pass_q, pass_d;
   logic [15:0]          err_q, err_d;
   // Stage 0 is aligned with dat_o; stage LATENCY is aligned with dut_out.
   logic [LATENCY:0]     pipe_vld_q, pipe_vld_d;
   logic [LATENCY:0]     pipe_exp_q, pipe_exp_d;
   logic                 push_vld;

   // Walking-zero pattern: all ones except bit k.
   function automatic logic [WIDTH-1:0] walk_pat(input logic [15:0] k);
      logic [WIDTH-1:0] one;
      one      = '0;
      one[0]   = 1'b1;
      walk_pat = ~(one << k);
   endfunction

`ifdef WIDE_AND_STIM_LFSR_EN
   logic [31:0] lfsr_q, lfsr_d;

   // Right-shifting Galois step for x^32 + x^22 + x^2 + x + 1.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   // LFSR state replicated LSB-first across WIDTH; every 8th pattern
   // (index mod 8 == 7) is forced to all ones so the result path sees 1s too.
   function automatic logic [WIDTH-1:0] lfsr_pat(input logic [31:0] s,
                                                 input logic [15:0] idx);
      logic [WIDTH-1:0] p;
      for (int j = 0; j < WIDTH; j++) begin
         p[j] = s[j % 32];
      end
      lfsr_pat = (idx[2:0] == 3'd7) ? '1 : p;
   endfunction
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dat_o_d  = '0;
      push_vld = 1'b0;
      pass_d   = pass_q;
      err_d    = err_q;
`ifdef WIDE_AND_STIM_LFSR_EN
      lfsr_d   = lfsr_q;
`endif

      if (pipe_vld_q[LATENCY] && (dut_out != pipe_exp_q[LATENCY]) &&
          (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = ONES;
               dat_o_d  = '1;
               push_vld = 1'b1;
               err_d    = '0;
               pass_d   = 1'b0;
`ifdef WIDE_AND_STIM_LFSR_EN
               lfsr_d   = 32'h1;
`endif
            end
         end
         ONES: begin
            state_d  = ZEROS;
            push_vld = 1'b1;
         end
         ZEROS: begin
            state_d  = WALK;
            cnt_d    = '0;
            dat_o_d  = walk_pat(16'd0);
            push_vld = 1'b1;
         end
         WALK: begin
            if (cnt_q == 16'(WIDTH - 1)) begin
               cnt_d = '0;
`ifdef WIDE_AND_STIM_LFSR_EN
               state_d  = LFSR;
               dat_o_d  = lfsr_pat(lfsr_q, 16'd0);
               lfsr_d   = lfsr_step(lfsr_q);
               push_vld = 1'b1;
`else
               state_d  = DRAIN;
`endif
            end else begin
               cnt_d    = cnt_q + 16'd1;
               dat_o_d  = walk_pat(cnt_q + 16'd1);
               push_vld = 1'b1;
            end
         end
`ifdef WIDE_AND_STIM_LFSR_EN
         LFSR: begin
            if (cnt_q == 16'(LFSR_COUNT - 1)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d    = cnt_q + 16'd1;
               dat_o_d  = lfsr_pat(lfsr_q, cnt_q + 16'd1);
               lfsr_d   = lfsr_step(lfsr_q);
               push_vld = 1'b1;
            end
         end
`endif
         DRAIN: begin
            if (cnt_q == 16'(LATENCY - 1)) begin
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         FIN: begin
            // The last valid expectation retired in the final DRAIN cycle.
            state_d = IDLE;
            pass_d  = (err_q == 16'd0);
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      pipe_vld_d = {pipe_vld_q[LATENCY-1:0], push_vld};
      pipe_exp_d = {pipe_exp_q[LATENCY-1:0], &dat_o_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dat_o_q    <= '0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         pipe_vld_q <= '0;
         pipe_exp_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dat_o_q    <= dat_o_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_exp_q <= pipe_exp_d;
      end
   end

`ifdef WIDE_AND_STIM_LFSR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 32'h1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`endif

   assign dat_o     = dat_o_q;
   assign busy      = (state_q != IDLE) && (state_q != FIN);
   assign done      = (state_q == FIN);
   assign pass      = pass_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_wide_and_stim_check.sv
`timescale 1ns/1ps

module tb_wide_and_stim_check;

   localparam int WIDTH      = 16;
   localparam int LATENCY    = 2;
   localparam int LFSR_COUNT = 256;
`ifdef WIDE_AND_STIM_LFSR_EN
   localparam int NPAT = 2 + WIDTH + LFSR_COUNT;
`else
   localparam int NPAT = 2 + WIDTH;
`endif
   localparam int DONE_CYC = NPAT + LATENCY + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dat_o;
   logic             dut_out;
   logic             busy, done, pass;
   logic [15:0]      err_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model of the stage under test, with fault injection:
   // 0 = correct wide AND, 1 = output stuck at 0, 2 = data bit 5 ignored.
   int               fault_mode = 0;
   bit [LATENCY-1:0] mdl_pipe = '0;
   logic [WIDTH-1:0] exp_pat [NPAT];

   always #5 clk = ~clk;

   wide_and_stim_check #(
      .WIDTH(WIDTH), .LATENCY(LATENCY), .LFSR_COUNT(LFSR_COUNT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dat_o(dat_o),
      .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count)
   );

   function automatic bit model_out(input int mode, input logic [WIDTH-1:0] p);
      logic [WIDTH-1:0] q;
      q = p;
      if (mode == 1) return 1'b0;
      if (mode == 2) q[5] = 1'b1;
      return &q;
   endfunction

   always @(posedge clk) begin
      for (int k = LATENCY - 1; k > 0; k--) mdl_pipe[k] <= mdl_pipe[k-1];
      mdl_pipe[0] <= model_out(fault_mode, dat_o);
   end
   assign dut_out = mdl_pipe[LATENCY-1];

   // Reference pattern list built straight from the burst definition.
   task automatic build_ref();
      logic [WIDTH-1:0] p;
      logic [31:0]      s;
      exp_pat[0] = '1;
      exp_pat[1] = '0;
      for (int k = 0; k < WIDTH; k++) begin
         p = '1;
         p[k] = 1'b0;
         exp_pat[2+k] = p;
      end
`ifdef WIDE_AND_STIM_LFSR_EN
      s = 32'h1;
      for (int i = 0; i < LFSR_COUNT; i++) begin
         for (int j = 0; j < WIDTH; j++) p[j] = s[j % 32];
         if (i % 8 == 7) p = '1;
         exp_pat[2+WIDTH+i] = p;
         s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      end
`else
      s = '0;
`endif
   endtask

   task automatic check_all_zero(input string name);
      n_cmp++;
      if ({dat_o, busy, done, pass, err_count} !== '0) begin
         n_fail++;
         $display("FAIL %s: dat_o=%h busy=%b done=%b pass=%b err=%0d required all 0",
                  name, dat_o, busy, done, pass, err_count);
      end
   endtask

   // One burst: start pulse, pattern-by-pattern and timing checks, results.
   task automatic run_burst(input int mode, input string name);
      int exp_err = 0;
      int done_at = -1;
      fault_mode = mode;
      for (int i = 0; i < NPAT; i++)
         if (model_out(mode, exp_pat[i]) != (&exp_pat[i])) exp_err++;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= DONE_CYC + 8 && done_at < 0; c++) begin
         if (c <= NPAT) begin
            n_cmp++;
            if (dat_o !== exp_pat[c-1]) begin
               n_fail++;
               $display("FAIL %s pattern %0d: dat_o=%h required %h",
                        name, c - 1, dat_o, exp_pat[c-1]);
            end
         end
         if (done === 1'b1) begin
            done_at = c;
         end else begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s busy cycle %0d: busy=%b required 1", name, c, busy);
            end
            @(posedge clk);
            #1;
         end
      end
      n_cmp++;
      if (done_at != DONE_CYC) begin
         n_fail++;
         $display("FAIL %s done cycle: got %0d required %0d", name, done_at, DONE_CYC);
      end
      n_cmp++;
      if (busy !== 1'b0 || err_count !== 16'(exp_err)) begin
         n_fail++;
         $display("FAIL %s at done: busy=%b err=%0d required busy=0 err=%0d",
                  name, busy, err_count, exp_err);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (pass !== (exp_err == 0) || done !== 1'b0 || err_count !== 16'(exp_err)) begin
         n_fail++;
         $display("FAIL %s after done: pass=%b done=%b err=%0d required pass=%b done=0 err=%0d",
                  name, pass, done, err_count, exp_err == 0, exp_err);
      end
      $display("burst %s: done at cycle %0d, err_count=%0d, pass=%b",
               name, done_at, err_count, pass);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1 check_all_zero("idle after reset");
      $display("reset: outputs checked");
   endtask

   task automatic test_reset_mid();
      int k;
`ifdef WIDE_AND_STIM_LFSR_EN
      k = $urandom_range(2 + WIDTH + 1, NPAT);
`else
      k = $urandom_range(1, NPAT);
`endif
      fault_mode = 0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (k - 1) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async reset mid-burst");
      @(posedge clk);
      #1 check_all_zero("held in reset");
      rst_n = 1'b1;
      $display("reset mid-burst at cycle %0d", k);
      run_burst(0, "after_reset");
   endtask

   task automatic test_start_held();
      int done_at = -1;
      fault_mode = 0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= DONE_CYC + 8 && done_at < 0; c++) begin
         if (done === 1'b1) done_at = c;
         else begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (done_at != DONE_CYC) begin
         n_fail++;
         $display("FAIL held done cycle: got %0d required %0d", done_at, DONE_CYC);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL held idle gap: busy=%b done=%b required 0 0", busy, done);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1 || dat_o !== {WIDTH{1'b1}}) begin
         n_fail++;
         $display("FAIL held restart: busy=%b dat_o=%h required busy=1 dat_o=all ones",
                  busy, dat_o);
      end
      start = 1'b0;
      done_at = -1;
      for (int c = 2; c <= DONE_CYC + 8 && done_at < 0; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) done_at = c;
      end
      n_cmp++;
      if (done_at != DONE_CYC) begin
         n_fail++;
         $display("FAIL held second done: got %0d required %0d", done_at, DONE_CYC);
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL held no third burst: busy=%b pass=%b required 0 1", busy, pass);
      end
      $display("start held: second burst done at cycle %0d", done_at);
   endtask

   initial begin
      build_ref();
      test_reset();
      run_burst(0, "correct");
      run_burst(1, "stuck0");
      run_burst(2, "bit5_ignored");
      run_burst(0, "correct_again");
      test_reset_mid();
      test_start_held();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
